// File: rtl/mem_bus_pkg.sv
// Shared encodings for the M-stage memory/device bridge: access widths,
// exception codes, FSM states and a width helper for device word offsets.
package mem_bus_pkg;

  localparam logic [1:0] WORD = 2'b00;
  localparam logic [1:0] HALF = 2'b01;
  localparam logic [1:0] BYTE = 2'b10;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_DBE  = 5'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } bus_state_e;

  // A single-word window still needs a 1-bit offset port.
  function automatic int woff_width(input int span);
    return (span / 4 > 1) ? $clog2(span / 4) : 1;
  endfunction

endpackage

// File: rtl/bus_addr_decode.sv
// Combinational address decoder: DM hit, one-hot device hit (lowest index
// wins on overlap) and the word offset inside the winning device window.
module bus_addr_decode
  import mem_bus_pkg::*;
#(
  parameter int                 NDEV     = 2,
  parameter logic [31:0]        DM_LIMIT = 32'h0000_3000,
  parameter logic [NDEV*32-1:0] DEV_BASE = {32'h0000_7F10, 32'h0000_7F00},
  parameter int                 DEV_SPAN = 12
) (
  input  logic [31:0]                         addr,
  output logic                                hit_dm,
  output logic [NDEV-1:0]                     hit_dev,
  output logic [woff_width(DEV_SPAN)-1:0]     woff
);

  localparam int WOFF_W = woff_width(DEV_SPAN);

  logic [31:0] base;
  logic        found;

  always_comb begin
    hit_dm  = (addr < DM_LIMIT);
    hit_dev = '0;
    woff    = '0;
    base    = '0;
    found   = 1'b0;
    for (int i = 0; i < NDEV; i++) begin
      base = DEV_BASE[i*32 +: 32];
      // 33-bit compare so a window ending at the top of memory cannot wrap.
      if (!found && ({1'b0, addr} >= {1'b0, base}) &&
          ({1'b0, addr} < ({1'b0, base} + 33'(DEV_SPAN)))) begin
        found      = 1'b1;
        hit_dev[i] = 1'b1;
        woff       = WOFF_W'((addr - base) >> 2);
      end
    end
  end

endmodule

// File: rtl/mem_bus_bridge.sv
// M-stage load/store router: DM accesses complete in place, device accesses
// run a req/ack handshake that stalls the pipeline until ack or timeout.
module mem_bus_bridge
  import mem_bus_pkg::*;
#(
  parameter int                                NDEV        = 2,
  parameter logic [31:0]                       DM_LIMIT    = 32'h0000_3000,
  parameter logic [NDEV*32-1:0]                DEV_BASE    = {32'h0000_7F10, 32'h0000_7F00},
  parameter int                                DEV_SPAN    = 12,
  parameter logic [NDEV*(DEV_SPAN/4)-1:0]      DEV_RO_MASK = {3'b100, 3'b100},
  parameter int                                TIMEOUT     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ld,
  input  logic                 st,
  input  logic [1:0]           width,
  input  logic [31:0]          addr,
  input  logic [31:0]          wdata,
  input  logic [4:0]           exc_in,
  input  logic                 int_req,
  output logic                 dm_we,
  output logic                 dm_hit,
  output logic                 pr_req,
  output logic [NDEV-1:0]      pr_sel,
  output logic                 pr_we,
  output logic [31:0]          pr_addr,
  output logic [31:0]          pr_wd,
  input  logic                 pr_ack,
  input  logic [NDEV*32-1:0]   pr_rd,
  output logic [31:0]          dev_rdata,
  output logic                 stall,
  output logic [4:0]           exc_code
);

  localparam int NW     = DEV_SPAN / 4;
  localparam int WOFF_W = woff_width(DEV_SPAN);
  localparam int CNT_W  = $clog2(TIMEOUT) + 1;

  bus_state_e        state_q, state_d;
  logic              req_q, req_d;
  logic [NDEV-1:0]   sel_q, sel_d;
  logic              we_q, we_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wd_q, wd_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              to_q, to_d;

  logic              hit_dm;
  logic [NDEV-1:0]   hit_dev;
  logic [WOFF_W-1:0] woff;
  logic              dev_hit;
  logic              ro_hit;
  logic              acc;
  logic [4:0]        bad_code;
  logic [4:0]        addr_exc;
  logic              clean;
  logic [31:0]       rd_sel;

  bus_addr_decode #(
    .NDEV     (NDEV),
    .DM_LIMIT (DM_LIMIT),
    .DEV_BASE (DEV_BASE),
    .DEV_SPAN (DEV_SPAN)
  ) u_decode (
    .addr    (addr),
    .hit_dm  (hit_dm),
    .hit_dev (hit_dev),
    .woff    (woff)
  );

  assign dev_hit  = |hit_dev;
  assign acc      = ld | st;
  assign bad_code = st ? EXC_ADES : EXC_ADEL;

  always_comb begin
    ro_hit = 1'b0;
    rd_sel = '0;
    for (int i = 0; i < NDEV; i++) begin
      if (hit_dev[i]) ro_hit = DEV_RO_MASK[i*NW + int'(woff)];
      if (sel_q[i])   rd_sel = pr_rd[i*32 +: 32];
    end
  end

  always_comb begin
    addr_exc = EXC_NONE;
    if (acc) begin
      if (!hit_dm && !dev_hit)
        addr_exc = bad_code;
      else if ((width == WORD && addr[1:0] != 2'b00) || (width == HALF && addr[0]))
        addr_exc = bad_code;
      else if (dev_hit && width != WORD)
        addr_exc = bad_code;
      else if (st && dev_hit && ro_hit)
        addr_exc = EXC_ADES;
    end
  end

  assign clean = (addr_exc == EXC_NONE) && (exc_in == EXC_NONE) && !int_req;

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    sel_d    = sel_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wd_d     = wd_q;
    rdata_d  = rdata_q;
    cnt_d    = cnt_q;
    to_d     = to_q;
    stall    = 1'b0;
    dm_we    = 1'b0;
    exc_code = exc_in;
    unique case (state_q)
      IDLE: begin
        if (exc_in == EXC_NONE) exc_code = addr_exc;
        dm_we = st & hit_dm & clean;
        if (acc && dev_hit && clean) begin
          stall   = 1'b1;
          req_d   = 1'b1;
          sel_d   = hit_dev;
          we_d    = st;
          addr_d  = addr;
          wd_d    = wdata;
          cnt_d   = '0;
          to_d    = 1'b0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        stall = 1'b1;
        cnt_d = cnt_q + CNT_W'(1);
        // Ack is checked first so an ack on the last allowed cycle still succeeds.
        if (pr_ack) begin
          rdata_d = rd_sel;
          req_d   = 1'b0;
          state_d = DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          req_d   = 1'b0;
          to_d    = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (to_q) exc_code = EXC_DBE;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wd_q    <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
    end
  end

  assign dm_hit    = hit_dm;
  assign pr_req    = req_q;
  assign pr_sel    = sel_q;
  assign pr_we     = we_q;
  assign pr_addr   = addr_q;
  assign pr_wd     = wd_q;
  assign dev_rdata = rdata_q;

endmodule

// File: tb/tb_mem_bus_bridge.sv
// Directed bench for mem_bus_bridge: a table of single-cycle decode vectors
// plus hand-written handshake, timeout and reset sequences.
module tb_mem_bus_bridge;

  localparam int NDEV    = 2;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              ld, st;
  logic [1:0]        width;
  logic [31:0]       addr, wdata;
  logic [4:0]        exc_in;
  logic              int_req;
  logic              dm_we, dm_hit, pr_req, pr_we, stall;
  logic [NDEV-1:0]   pr_sel;
  logic [31:0]       pr_addr, pr_wd, dev_rdata;
  logic              pr_ack;
  logic [NDEV*32-1:0] pr_rd;
  logic [4:0]        exc_code;

  int n_vec  = 0;
  int n_miss = 0;

  mem_bus_bridge #(
    .NDEV        (NDEV),
    .DM_LIMIT    (32'h0000_3000),
    .DEV_BASE    ({32'h0000_7F10, 32'h0000_7F00}),
    .DEV_SPAN    (12),
    .DEV_RO_MASK ({3'b100, 3'b100}),
    .TIMEOUT     (TIMEOUT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ld        (ld),
    .st        (st),
    .width     (width),
    .addr      (addr),
    .wdata     (wdata),
    .exc_in    (exc_in),
    .int_req   (int_req),
    .dm_we     (dm_we),
    .dm_hit    (dm_hit),
    .pr_req    (pr_req),
    .pr_sel    (pr_sel),
    .pr_we     (pr_we),
    .pr_addr   (pr_addr),
    .pr_wd     (pr_wd),
    .pr_ack    (pr_ack),
    .pr_rd     (pr_rd),
    .dev_rdata (dev_rdata),
    .stall     (stall),
    .exc_code  (exc_code)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        ld;
    logic        st;
    logic [1:0]  width;
    logic [31:0] addr;
    logic [4:0]  exc_in;
    logic        int_req;
    logic        e_dm_we;
    logic        e_dm_hit;
    logic        e_stall;
    logic [4:0]  e_exc;
  } vec_t;

  localparam int NV = 19;
  vec_t tbl [NV];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    ld = 0; st = 0; width = 2'b00; addr = '0; wdata = '0;
    exc_in = '0; int_req = 0; pr_ack = 0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    //              ld st  w      addr           exc_in int  dmwe hit stall exc
    tbl[0]  = '{1'b0, 1'b1, 2'b00, 32'h0000_1000, 5'd0,  1'b0, 1'b1, 1'b1, 1'b0, 5'd0};
    tbl[1]  = '{1'b1, 1'b0, 2'b00, 32'h0000_1000, 5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 5'd0};
    tbl[2]  = '{1'b0, 1'b1, 2'b00, 32'h0000_7F18, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 5'd5};
    tbl[3]  = '{1'b1, 1'b0, 2'b01, 32'h0000_7F10, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 5'd4};
    tbl[4]  = '{1'b1, 1'b0, 2'b00, 32'h0000_0002, 5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 5'd4};
    tbl[5]  = '{1'b1, 1'b0, 2'b00, 32'h0000_5000, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 5'd4};
    tbl[6]  = '{1'b0, 1'b1, 2'b00, 32'h0000_5000, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 5'd5};
    tbl[7]  = '{1'b0, 1'b1, 2'b01, 32'h0000_1001, 5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 5'd5};
    tbl[8]  = '{1'b0, 1'b1, 2'b10, 32'h0000_1003, 5'd0,  1'b0, 1'b1, 1'b1, 1'b0, 5'd0};
    tbl[9]  = '{1'b0, 1'b1, 2'b00, 32'h0000_1000, 5'd10, 1'b0, 1'b0, 1'b1, 1'b0, 5'd10};
    tbl[10] = '{1'b0, 1'b1, 2'b00, 32'h0000_1000, 5'd0,  1'b1, 1'b0, 1'b1, 1'b0, 5'd0};
    tbl[11] = '{1'b0, 1'b1, 2'b00, 32'h0000_7F14, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 5'd0};
    tbl[12] = '{1'b1, 1'b0, 2'b00, 32'h0000_2FFC, 5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 5'd0};
    tbl[13] = '{1'b1, 1'b0, 2'b00, 32'h0000_3000, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 5'd4};
    tbl[14] = '{1'b1, 1'b0, 2'b00, 32'h0000_7F0C, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 5'd4};
    tbl[15] = '{1'b0, 1'b1, 2'b00, 32'h0000_7F08, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 5'd5};
    tbl[16] = '{1'b0, 1'b0, 2'b00, 32'h0000_5000, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 5'd0};
    tbl[17] = '{1'b1, 1'b0, 2'b00, 32'h0000_7F1C, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 5'd4};
    tbl[18] = '{1'b1, 1'b0, 2'b10, 32'h0000_7F04, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 5'd4};

    idle_inputs();
    pr_rd = '0;
    reset = 1;
    tick();
    tick();
    #2;
    chk("rst pr_req", 32'(pr_req), 32'd0);
    chk("rst pr_sel", 32'(pr_sel), 32'd0);
    chk("rst pr_we", 32'(pr_we), 32'd0);
    chk("rst pr_addr", pr_addr, 32'd0);
    chk("rst pr_wd", pr_wd, 32'd0);
    chk("rst dev_rdata", dev_rdata, 32'd0);
    chk("rst stall", 32'(stall), 32'd0);
    reset = 0;
    tick();

    for (int k = 0; k < NV; k++) begin
      ld = tbl[k].ld; st = tbl[k].st; width = tbl[k].width; addr = tbl[k].addr;
      exc_in = tbl[k].exc_in; int_req = tbl[k].int_req; wdata = 32'hA5A5_0000 + k;
      #2;
      chk($sformatf("vec%0d dm_we", k), 32'(dm_we), 32'(tbl[k].e_dm_we));
      chk($sformatf("vec%0d dm_hit", k), 32'(dm_hit), 32'(tbl[k].e_dm_hit));
      chk($sformatf("vec%0d stall", k), 32'(stall), 32'(tbl[k].e_stall));
      chk($sformatf("vec%0d exc_code", k), 32'(exc_code), 32'(tbl[k].e_exc));
      tick();
      chk($sformatf("vec%0d no pr_req", k), 32'(pr_req), 32'd0);
    end
    idle_inputs();
    tick();

    // lw to device 0, ack in the third WAIT cycle
    ld = 1; addr = 32'h0000_7F04; pr_rd = {32'h0, 32'hDEAD_BEEF};
    #2;
    chk("A idle stall", 32'(stall), 32'd1);
    chk("A idle pr_req", 32'(pr_req), 32'd0);
    tick();
    chk("A w1 stall", 32'(stall), 32'd1);
    chk("A w1 pr_req", 32'(pr_req), 32'd1);
    chk("A pr_sel", 32'(pr_sel), 32'd1);
    chk("A pr_addr", pr_addr, 32'h0000_7F04);
    chk("A pr_we", 32'(pr_we), 32'd0);
    tick();
    chk("A w2 stall", 32'(stall), 32'd1);
    tick();
    pr_ack = 1;
    #2;
    chk("A w3 stall", 32'(stall), 32'd1);
    tick();
    pr_ack = 0;
    #2;
    chk("A done stall", 32'(stall), 32'd0);
    chk("A done pr_req", 32'(pr_req), 32'd0);
    chk("A dev_rdata", dev_rdata, 32'hDEAD_BEEF);
    chk("A exc_code", 32'(exc_code), 32'd0);
    ld = 0;
    tick();
    chk("A back idle stall", 32'(stall), 32'd0);

    // sw to device 1 word 0, ack in the first WAIT cycle
    st = 1; addr = 32'h0000_7F10; wdata = 32'h1234_5678;
    pr_rd = {32'hCAFE_F00D, 32'h1111_1111};
    tick();
    chk("B pr_sel", 32'(pr_sel), 32'd2);
    chk("B pr_we", 32'(pr_we), 32'd1);
    chk("B pr_wd", pr_wd, 32'h1234_5678);
    chk("B pr_addr", pr_addr, 32'h0000_7F10);
    pr_ack = 1;
    tick();
    pr_ack = 0;
    #2;
    chk("B dev_rdata ch1", dev_rdata, 32'hCAFE_F00D);
    chk("B done stall", 32'(stall), 32'd0);
    st = 0;
    tick();

    // lw to device 0 with no ack: TIMEOUT WAIT cycles then bus error
    ld = 1; addr = 32'h0000_7F00;
    tick();
    n = 0;
    while (stall === 1'b1 && n < 4 * TIMEOUT) begin
      n++;
      tick();
    end
    chk("C wait cycles", 32'(n), 32'(TIMEOUT));
    #2;
    chk("C exc_code", 32'(exc_code), 32'd7);
    chk("C stall", 32'(stall), 32'd0);
    chk("C pr_req", 32'(pr_req), 32'd0);
    ld = 0;
    tick();
    chk("C idle exc_code", 32'(exc_code), 32'd0);

    // same access, ack arriving on the last allowed WAIT cycle
    ld = 1; addr = 32'h0000_7F00; pr_rd = {32'h0, 32'h0BAD_F00D};
    tick();
    for (int k = 1; k < TIMEOUT; k++) tick();
    pr_ack = 1;
    #2;
    chk("D last wait stall", 32'(stall), 32'd1);
    tick();
    pr_ack = 0;
    #2;
    chk("D exc_code", 32'(exc_code), 32'd0);
    chk("D stall", 32'(stall), 32'd0);
    chk("D dev_rdata", dev_rdata, 32'h0BAD_F00D);
    ld = 0;
    tick();

    // int_req raised mid-WAIT does not abort the access
    ld = 1; addr = 32'h0000_7F08; pr_rd = {32'h0, 32'h5A5A_1234};
    tick();
    int_req = 1;
    tick();
    pr_ack = 1;
    #2;
    chk("F wait stall", 32'(stall), 32'd1);
    chk("F wait pr_req", 32'(pr_req), 32'd1);
    tick();
    pr_ack = 0;
    #2;
    chk("F dev_rdata", dev_rdata, 32'h5A5A_1234);
    chk("F exc_code", 32'(exc_code), 32'd0);
    ld = 0; int_req = 0;
    tick();

    // reset in the second WAIT cycle
    ld = 1; addr = 32'h0000_7F04; pr_rd = {32'h0, 32'h7777_8888};
    tick();
    tick();
    #2;
    chk("E w2 pr_req", 32'(pr_req), 32'd1);
    reset = 1; ld = 0;
    tick();
    reset = 0;
    #2;
    chk("E pr_req", 32'(pr_req), 32'd0);
    chk("E dev_rdata", dev_rdata, 32'd0);
    chk("E stall", 32'(stall), 32'd0);
    chk("E pr_sel", 32'(pr_sel), 32'd0);
    tick();
    chk("E stays idle", 32'(pr_req), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
